// File: rtl/barrett_reduce_pipe_pkg.sv
// Shared constants, mode encoding and width helper for the Barrett reduction pipeline.
// Defaults target the Kyber modulus with a 26-bit Barrett shift.
package pqc_barrett_pkg;

  localparam int KYBER_Q       = 3329;
  localparam int BARRETT_V     = 20159;
  localparam int BARRETT_SHIFT = 26;

  typedef enum logic {
    BARRETT_CENTRED   = 1'b0,
    BARRETT_CANONICAL = 1'b1
  } barrett_mode_e;

  // Width of a*V plus the rounding constant, with one bit of headroom for the sign.
  function automatic int barrett_prod_w(input int data_w, input int v);
    return data_w + $clog2(v) + 1;
  endfunction

endpackage

// File: rtl/barrett_lane_pipe.sv
// One reduction lane: three datapath register stages sharing a single advance enable.
// Control (valid, tag, mode chain) lives in the parent; this lane is data only.
module barrett_lane_pipe #(
  parameter int DATA_W        = 16,
  parameter int Q             = pqc_barrett_pkg::KYBER_Q,
  parameter int BARRETT_V     = pqc_barrett_pkg::BARRETT_V,
  parameter int BARRETT_SHIFT = pqc_barrett_pkg::BARRETT_SHIFT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  pqc_barrett_pkg::barrett_mode_e mode,
  input  logic signed [DATA_W-1:0]       a,
  output logic signed [DATA_W-1:0]       y
);
  import pqc_barrett_pkg::*;

  localparam int                       PROD_W  = barrett_prod_w(DATA_W, BARRETT_V);
  localparam logic signed [PROD_W-1:0] V_C     = PROD_W'(BARRETT_V);
  localparam logic signed [PROD_W-1:0] ROUND_C = PROD_W'(64'(1) << (BARRETT_SHIFT - 1));
  localparam logic [31:0]              Q_BITS  = 32'(Q);

  logic signed [PROD_W-1:0] p_d, p_q;
  logic signed [PROD_W-1:0] t;
  logic signed [PROD_W-1:0] tq;
  logic signed [DATA_W-1:0] a_q;
  logic signed [DATA_W-1:0] r_d, r_q;
  logic signed [DATA_W-1:0] y_d;

  // Stage 1: rounded Barrett product.
  assign p_d = PROD_W'(a) * V_C + ROUND_C;

  // Stage 2: quotient estimate, then t*Q as a sum of shifted copies of t.
  assign t = p_q >>> BARRETT_SHIFT;

  // NOTE: tq gets a value before the loop so every path assigns it and no latch is inferred.
  always_comb begin
    tq = '0;
    for (int i = 0; i < 32; i++) begin
      if (Q_BITS[i]) tq = tq + (t <<< i);
    end
  end

  assign r_d = DATA_W'(PROD_W'(a_q) - tq);

  // Stage 3: centred result is already in range; canonical folds negatives up by Q.
  assign y_d = (mode == BARRETT_CANONICAL && r_q[DATA_W-1]) ? r_q + DATA_W'(Q) : r_q;

  // NOTE: datapath registers are reset too, so data_o reads 0 out of reset rather than X;
  // state is updated with <= so every stage samples the previous stage's old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
      a_q <= '0;
      r_q <= '0;
      y   <= '0;
    end else if (en) begin
      p_q <= p_d;
      a_q <= a;
      r_q <= r_d;
      y   <= y_d;
    end
  end

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Multi-lane, three-stage Barrett reduction mod Q with valid/ready on both sides.
// A global stall freezes every stage whenever the output beat is held by downstream.
module barrett_reduce_pipe #(
  parameter int LANES         = 4,
  parameter int DATA_W        = 16,
  parameter int Q             = pqc_barrett_pkg::KYBER_Q,
  parameter int BARRETT_V     = pqc_barrett_pkg::BARRETT_V,
  parameter int BARRETT_SHIFT = pqc_barrett_pkg::BARRETT_SHIFT,
  parameter int TAG_W         = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    mode_i,
  input  logic [TAG_W-1:0]        tag_i,
  input  logic [LANES*DATA_W-1:0] data_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [TAG_W-1:0]        tag_o,
  output logic [LANES*DATA_W-1:0] data_o
);
  import pqc_barrett_pkg::*;

  logic          adv;
  logic          v1_q, v2_q, v3_q;
  barrett_mode_e m1_q, m2_q;
  logic [TAG_W-1:0] t1_q, t2_q, t3_q;

  // Advance whenever the output slot is empty or being consumed this cycle.
  assign adv     = ~v3_q | ready_i;
  assign ready_o = adv;
  assign valid_o = v3_q;
  assign tag_o   = t3_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      m1_q <= BARRETT_CENTRED;
      m2_q <= BARRETT_CENTRED;
      t1_q <= '0;
      t2_q <= '0;
      t3_q <= '0;
    end else if (adv) begin
      v1_q <= valid_i;
      v2_q <= v1_q;
      v3_q <= v2_q;
      m1_q <= barrett_mode_e'(mode_i);
      m2_q <= m1_q;
      t1_q <= tag_i;
      t2_q <= t1_q;
      t3_q <= t2_q;
    end
  end

  // Stage-2 mode accompanies r into the final fold, so that is the copy lanes see.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    barrett_lane_pipe #(
      .DATA_W       (DATA_W),
      .Q            (Q),
      .BARRETT_V    (BARRETT_V),
      .BARRETT_SHIFT(BARRETT_SHIFT)
    ) u_lane (
      .clk  (clk_i),
      .rst_n(rstn_i),
      .en   (adv),
      .mode (m2_q),
      .a    (data_i[k*DATA_W +: DATA_W]),
      .y    (data_o[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Scoreboard bench for barrett_reduce_pipe: golden (a mod Q) model, directed corners,
// throughput, stall, mid-flight reset and random valid/ready traffic.
module tb_barrett_reduce_pipe;

  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int Q      = 3329;
  localparam int TAG_W  = 4;
  localparam int BW     = LANES * DATA_W;

  logic              clk = 1'b0;
  logic              rstn_i;
  logic              valid_i;
  logic              ready_o;
  logic              mode_i;
  logic [TAG_W-1:0]  tag_i;
  logic [BW-1:0]     data_i;
  logic              valid_o;
  logic              ready_i;
  logic [TAG_W-1:0]  tag_o;
  logic [BW-1:0]     data_o;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [BW-1:0]    data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;

  barrett_reduce_pipe #(
    .LANES(LANES), .DATA_W(DATA_W), .Q(Q), .BARRETT_V(20159), .BARRETT_SHIFT(26), .TAG_W(TAG_W)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .mode_i (mode_i),
    .tag_i  (tag_i),
    .data_i (data_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .tag_o  (tag_o),
    .data_o (data_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DATA_W-1:0] golden(input logic [DATA_W-1:0] a, input logic mode);
    int v;
    int m;
    v = $signed(a);
    m = v % Q;
    if (m < 0) m += Q;
    if (!mode && m > (Q - 1) / 2) m -= Q;
    return DATA_W'(m);
  endfunction

  function automatic logic [BW-1:0] golden_beat(input logic [BW-1:0] d, input logic mode);
    logic [BW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*DATA_W +: DATA_W] = golden(d[k*DATA_W +: DATA_W], mode);
    return r;
  endfunction

  function automatic logic [BW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    logic [BW-1:0] r;
    r[0*DATA_W +: DATA_W] = DATA_W'(l0);
    r[1*DATA_W +: DATA_W] = DATA_W'(l1);
    r[2*DATA_W +: DATA_W] = DATA_W'(l2);
    r[3*DATA_W +: DATA_W] = DATA_W'(l3);
    return r;
  endfunction

  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] r;
    for (int k = 0; k < LANES; k++) begin
      case ($urandom_range(0, 5))
        0:       r[k*DATA_W +: DATA_W] = 16'h8000;
        1:       r[k*DATA_W +: DATA_W] = 16'h7fff;
        2:       r[k*DATA_W +: DATA_W] = DATA_W'(Q * $urandom_range(0, 9) + 1664 + $urandom_range(0, 1));
        3:       r[k*DATA_W +: DATA_W] = DATA_W'(-(Q * $urandom_range(0, 9) + 1664 + $urandom_range(0, 1)));
        default: r[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      endcase
    end
    return r;
  endfunction

  // Handshakes are judged at the falling edge; they complete on the following rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rstn_i === 1'b1) begin
      if (valid_o && ready_i) begin
        n_checks++;
        n_out++;
        if (sb.size() == 0) begin
          $display("FAIL scoreboard_unexpected: got data=%h tag=%h with no beat outstanding", data_o, tag_o);
        end else begin
          e = sb.pop_front();
          if (data_o !== e.data || tag_o !== e.tag)
            $display("FAIL scoreboard_beat %0d: got data=%h tag=%h, want data=%h tag=%h",
                     n_out, data_o, tag_o, e.data, e.tag);
          else n_pass++;
        end
      end
      if (valid_i && ready_o) sb.push_back('{tag: tag_i, data: golden_beat(data_i, mode_i)});
    end
  end

  task automatic drive_beat(input logic [BW-1:0] d, input logic m, input logic [TAG_W-1:0] t,
                            output int cycles);
    bit acc;
    acc    = 1'b0;
    cycles = 0;
    valid_i = 1'b1;
    data_i  = d;
    mode_i  = m;
    tag_i   = t;
    while (!acc) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      cycles++;
      if (cycles > 200) begin
        n_checks++;
        $display("FAIL accept_timeout: beat not accepted after %0d cycles, want acceptance", cycles);
        break;
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic send_and_wait(input logic [BW-1:0] d, input logic m, input logic [TAG_W-1:0] t,
                               output int lat, output logic [BW-1:0] q);
    int cyc;
    drive_beat(d, m, t, cyc);
    lat = 1;
    while (!valid_o && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q = data_o;
  endtask

  task automatic drain();
    int guard;
    guard   = 0;
    ready_i = 1'b1;
    while (sb.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) $display("FAIL drain: %0d beats outstanding, want 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rstn_i  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    mode_i  = 1'b0;
    tag_i   = '0;
    data_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else n_pass++;
    n_checks++; if (data_o !== '0) $display("FAIL reset_data: got %h want 0", data_o); else n_pass++;
    n_checks++; if (tag_o !== '0) $display("FAIL reset_tag: got %h want 0", tag_o); else n_pass++;
    @(negedge clk);
    #2;
    rstn_i = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_o); else n_pass++;
    ready_i = 1'b1;
  endtask

  task automatic test_directed();
    int lat;
    logic [BW-1:0] q;
    logic [BW-1:0] corner;
    corner = pack4(3329, -1, 32767, -32768);

    send_and_wait(corner, 1'b0, 4'h5, lat, q);
    n_checks++; if (lat != 3) $display("FAIL centred_latency: got %0d want 3", lat); else n_pass++;
    n_checks++; if (q !== pack4(0, -1, -523, 522)) $display("FAIL centred_corner: got %h want %h", q, pack4(0, -1, -523, 522)); else n_pass++;
    drain();

    send_and_wait(corner, 1'b1, 4'ha, lat, q);
    n_checks++; if (lat != 3) $display("FAIL canonical_latency: got %0d want 3", lat); else n_pass++;
    n_checks++; if (q !== pack4(0, 3328, 2806, 522)) $display("FAIL canonical_corner: got %h want %h", q, pack4(0, 3328, 2806, 522)); else n_pass++;
    drain();

    send_and_wait(pack4(1664, 1665, -1665, -1664), 1'b0, 4'h3, lat, q);
    n_checks++; if (q !== pack4(1664, -1664, 1664, -1664)) $display("FAIL centred_half_q: got %h want %h", q, pack4(1664, -1664, 1664, -1664)); else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    int cyc;
    int total;
    int out0;
    total   = 0;
    out0    = n_out;
    ready_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_beat(rand_beat(), i[0], TAG_W'(i), cyc);
      total += cyc;
    end
    n_checks++; if (total != 100) $display("FAIL b2b_throughput: got %0d cycles want 100", total); else n_pass++;
    drain();
    n_checks++; if (n_out - out0 != 100) $display("FAIL b2b_count: got %0d outputs want 100", n_out - out0); else n_pass++;
  endtask

  task automatic test_stall();
    int cyc;
    int out0;
    logic [BW-1:0]    snap_d;
    logic [TAG_W-1:0] snap_t;
    out0    = n_out;
    ready_i = 1'b1;
    drive_beat(pack4(100, -200, 4000, -5000), 1'b0, 4'h1, cyc);
    drive_beat(pack4(7000, -7000, 1665, 0), 1'b1, 4'h2, cyc);
    drive_beat(pack4(-1, 1, 3328, -3329), 1'b0, 4'h3, cyc);
    ready_i = 1'b0;
    snap_d  = data_o;
    snap_t  = tag_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (ready_o !== 1'b0 || valid_o !== 1'b1 || data_o !== snap_d || tag_o !== snap_t)
        $display("FAIL stall_hold cycle %0d: got ready_o=%b valid_o=%b data=%h tag=%h, want 0 1 %h %h",
                 i, ready_o, valid_o, data_o, tag_o, snap_d, snap_t);
      else n_pass++;
    end
    @(posedge clk);
    #1;
    drain();
    n_checks++; if (n_out - out0 != 3) $display("FAIL stall_count: got %0d outputs want 3", n_out - out0); else n_pass++;
  endtask

  task automatic test_reset_flush();
    int cyc;
    int out0;
    ready_i = 1'b1;
    drive_beat(pack4(11, 22, 33, 44), 1'b1, 4'h7, cyc);
    drive_beat(pack4(55, 66, 77, 88), 1'b0, 4'h8, cyc);
    drive_beat(pack4(99, 111, 222, 333), 1'b1, 4'h9, cyc);
    rstn_i = 1'b0;
    sb.delete();
    out0 = n_out;
    #1;
    n_checks++;
    if (valid_o !== 1'b0 || data_o !== '0 || tag_o !== '0)
      $display("FAIL flush_async: got valid_o=%b data=%h tag=%h, want 0 0 0", valid_o, data_o, tag_o);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rstn_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (n_out != out0 || valid_o !== 1'b0)
      $display("FAIL flush_stale: got %0d outputs valid_o=%b after reset, want 0 and 0", n_out - out0, valid_o);
    else n_pass++;
  endtask

  task automatic test_random(input int n_beats);
    int  sent;
    int  cyc;
    int  out0;
    bit  acc;
    sent    = 0;
    cyc     = 0;
    out0    = n_out;
    valid_i = 1'b0;
    ready_i = 1'b1;
    while (sent < n_beats && cyc < 40000) begin
      @(negedge clk);
      acc = valid_i && ready_o;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) sent++;
      if (acc || !valid_i) begin
        valid_i = ($urandom_range(0, 3) != 0);
        if (valid_i) begin
          data_i = rand_beat();
          mode_i = 1'($urandom);
          tag_i  = TAG_W'($urandom);
        end
      end
      ready_i = ($urandom_range(0, 3) != 0);
    end
    valid_i = 1'b0;
    drain();
    n_checks++;
    if (sent != n_beats || n_out - out0 != sent)
      $display("FAIL random_count: sent %0d received %0d, want %0d each", sent, n_out - out0, n_beats);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    test_random(3000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
